// File: rtl/aes_pkg.sv
// Shared AES constants: forward and inverse S-box tables plus lookup helpers.
// Imported by the per-lane lookup and the SubBytes pipeline.
package aes_pkg;

   localparam int AES_BLOCK_BYTES = 16;

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   localparam logic [7:0] INV_SBOX [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
      return SBOX[b];
   endfunction

   function automatic logic [7:0] sbox_inv(input logic [7:0] b);
      return INV_SBOX[b];
   endfunction

endpackage

// File: rtl/aes_sbox_lane.sv
// One byte lane of SubBytes: combinational forward or inverse S-box lookup.
// With INV_EN = 0 only the forward table is built and inv has no effect.
import aes_pkg::*;

module aes_sbox_lane #(
   parameter int INV_EN = 1
) (
   input  logic [7:0] a,
   input  logic       inv,
   output logic [7:0] c
);

   always_comb begin
      if ((INV_EN != 0) && inv) begin
         c = sbox_inv(a);
      end else begin
         c = sbox_fwd(a);
      end
   end

endmodule

// File: rtl/aes_sub_bytes_pipe.sv
// Two-stage SubBytes pipeline with valid/ready on both sides and per-beat mode.
// S1 captures the input beat; lookups sit between S1 and the output stage.
import aes_pkg::*;

module aes_sub_bytes_pipe #(
   parameter int LANES  = 4,
   parameter int INV_EN = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [8*LANES-1:0] in_data,
   input  logic               in_inv,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [8*LANES-1:0] out_data,
   output logic               out_inv
);

   if (LANES != 1 && LANES != 4 && LANES != AES_BLOCK_BYTES) begin : g_bad_lanes
      $error("aes_sub_bytes_pipe: LANES must be 1, 4 or 16");
   end

   logic               s1_valid_q, s1_valid_d;
   logic [8*LANES-1:0] s1_data_q,  s1_data_d;
   logic               s1_inv_q,   s1_inv_d;
   logic               out_valid_q, out_valid_d;
   logic [8*LANES-1:0] out_data_q,  out_data_d;
   logic               out_inv_q,   out_inv_d;
   logic [8*LANES-1:0] lut_data;
   logic               adv1, adv2, accept;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      aes_sbox_lane #(.INV_EN(INV_EN)) u_lane (
         .a   (s1_data_q[8*i +: 8]),
         .inv (s1_inv_q),
         .c   (lut_data[8*i +: 8])
      );
   end

   // A stage may load when it is empty or when its contents leave this edge.
   assign adv2     = !out_valid_q || out_ready;
   assign adv1     = !s1_valid_q || adv2;
   assign in_ready = adv1 && !rst;
   assign accept   = in_valid && in_ready;

   // NOTE: every _d starts from its _q so no branch leaves a signal unassigned and no latch is inferred.
   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_data_d   = s1_data_q;
      s1_inv_d    = s1_inv_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_inv_d   = out_inv_q;
      if (accept) begin
         s1_valid_d = 1'b1;
         s1_data_d  = in_data;
         s1_inv_d   = (INV_EN != 0) && in_inv;
      end else if (adv1) begin
         s1_valid_d = 1'b0;
      end
      if (adv2) begin
         out_valid_d = s1_valid_q;
         out_data_d  = lut_data;
         out_inv_d   = s1_inv_q;
      end
   end

   // NOTE: data registers are reset as well, so out_data reads 0 out of reset instead of stale state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_data_q   <= '0;
         s1_inv_q    <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_inv_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking so both stages sample pre-edge values and shift together.
         s1_valid_q  <= s1_valid_d;
         s1_data_q   <= s1_data_d;
         s1_inv_q    <= s1_inv_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_inv_q   <= out_inv_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_inv   = out_inv_q;

endmodule

// File: tb/tb_aes_sub_bytes_pipe.sv
// Self-checking bench for aes_sub_bytes_pipe: vector table, directed flow-control
// sequences and a random scoreboard against an S-box model built from GF(2^8) math.
module tb_aes_sub_bytes_pipe;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   // main instance: LANES = 4, inverse enabled
   logic        in_valid = 1'b0, in_inv = 1'b0, out_ready = 1'b1;
   logic [31:0] in_data = '0;
   logic        in_ready, out_valid, out_inv;
   logic [31:0] out_data;

   aes_sub_bytes_pipe #(.LANES(4), .INV_EN(1)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_inv(in_inv),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_inv(out_inv)
   );

   // LANES = 16 sweep instance
   logic         v16 = 1'b0, inv16 = 1'b0;
   logic [127:0] d16 = '0;
   logic         rdy16, ov16, oinv16;
   logic [127:0] od16;

   aes_sub_bytes_pipe #(.LANES(16), .INV_EN(1)) dut16 (
      .clk(clk), .rst(rst),
      .in_valid(v16), .in_ready(rdy16), .in_data(d16), .in_inv(inv16),
      .out_valid(ov16), .out_ready(1'b1), .out_data(od16), .out_inv(oinv16)
   );

   // LANES = 1, forward-only instance
   logic       vf = 1'b0, invf = 1'b0;
   logic [7:0] df = '0;
   logic       rdyf, ovf, oinvf;
   logic [7:0] odf;

   aes_sub_bytes_pipe #(.LANES(1), .INV_EN(0)) dutf (
      .clk(clk), .rst(rst),
      .in_valid(vf), .in_ready(rdyf), .in_data(df), .in_inv(invf),
      .out_valid(ovf), .out_ready(1'b1), .out_data(odf), .out_inv(oinvf)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // ---------------- reference model: S-box from field inverse + affine map
   logic [7:0] model_fwd [256];
   logic [7:0] model_inv [256];

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = '0;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
      return 8'((x << n) | (x >> (8 - n)));
   endfunction

   function automatic logic [7:0] affine_of_inverse(input logic [7:0] a);
      logic [7:0] r = 8'h01;
      for (int i = 0; i < 254; i++) r = gmul(r, a);
      return r ^ rotl(r, 1) ^ rotl(r, 2) ^ rotl(r, 3) ^ rotl(r, 4) ^ 8'h63;
   endfunction

   task automatic build_model();
      for (int x = 0; x < 256; x++) model_fwd[x] = affine_of_inverse(8'(x));
      for (int x = 0; x < 256; x++) model_inv[model_fwd[x]] = 8'(x);
   endtask

   function automatic logic [31:0] exp_word(input logic [31:0] d, input logic m);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = m ? model_inv[d[8*i +: 8]] : model_fwd[d[8*i +: 8]];
      return r;
   endfunction

   // ---------------- scoreboard on the main instance
   typedef struct {
      logic [31:0] data;
      logic        inv;
   } beat_t;

   beat_t sb_q[$];
   logic  sb_en  = 1'b0;
   int    popped = 0;

   always @(negedge clk) begin
      if (rst) begin
         sb_q.delete();
      end else if (sb_en) begin
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_extra: actual=%0h required=no beat", out_data);
            end else begin
               beat_t e;
               e = sb_q.pop_front();
               check("sb_data", out_data, e.data);
               check("sb_inv", out_inv, e.inv);
               popped++;
            end
         end
         if (in_valid && in_ready) sb_q.push_back('{exp_word(in_data, in_inv), in_inv});
      end
   end

   // random traffic with alternating mode per accepted beat
   task automatic run_random(input int n_beats, input int max_cyc);
      int sent = 0;
      for (int c = 0; c < max_cyc && sent < n_beats; c++) begin
         @(posedge clk); #1;
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = $urandom;
         in_inv    = sent[0];
         out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (in_valid && in_ready) sent++;
      end
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("rand_sent", sent, n_beats);
      check("rand_drained", sb_q.size(), 0);
   endtask

   function automatic logic [31:0] bp_data(input int i);
      return 32'h10203040 + 32'(i) * 32'h01010101;
   endfunction

   typedef struct {
      string       name;
      logic [31:0] din;
      logic        inv;
      logic [31:0] dout;
   } vec_t;

   vec_t vecs[6];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      build_model();

      vecs[0] = '{"fwd_spec",   32'hFF530100, 1'b0, 32'h16ED7C63};
      vecs[1] = '{"inv_spec",   32'h16ED7C63, 1'b1, 32'hFF530100};
      vecs[2] = '{"inv_zero",   32'h00000000, 1'b1, 32'h52525252};
      vecs[3] = '{"fwd_52",     32'h52525252, 1'b0, 32'h00000000};
      vecs[4] = '{"fwd_misc",   32'h00112233, 1'b0, 32'h638293C3};
      vecs[5] = '{"inv_misc",   32'h638293C3, 1'b1, 32'h00112233};

      // ---- reset asserted mid-cycle, then released
      #3 rst = 1'b1;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_inv", out_inv, 0);
      check("rst_in_ready", in_ready, 0);
      repeat (2) @(posedge clk);
      #1 check("rst_in_ready_held", in_ready, 0);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      check("post_rst_in_ready", in_ready, 1);
      check("post_rst_out_valid", out_valid, 0);

      // ---- table vectors: one beat each, latency checked on the way
      for (int v = 0; v < 6; v++) begin
         @(posedge clk); #1;
         in_valid = 1'b1; in_data = vecs[v].din; in_inv = vecs[v].inv; out_ready = 1'b1;
         @(posedge clk); #1;
         in_valid = 1'b0;
         check({vecs[v].name, "_lat1"}, out_valid, 0);
         @(posedge clk); #1;
         check({vecs[v].name, "_valid"}, out_valid, 1);
         check({vecs[v].name, "_data"}, out_data, vecs[v].dout);
         check({vecs[v].name, "_inv"}, out_inv, vecs[v].inv);
      end
      @(posedge clk); #1;

      // ---- back-to-back: 8 beats, one result per cycle, no bubble
      sb_en = 1'b1;
      begin
         int base;
         base = popped;
         for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in_data = $urandom; in_inv = 1'b0; out_ready = 1'b1;
            @(negedge clk);
            check("b2b_in_ready", in_ready, 1);
         end
         @(posedge clk); #1;
         in_valid = 1'b0;
         @(negedge clk);
         @(negedge clk); #1;
         check("b2b_throughput", popped - base, 8);
      end

      // ---- backpressure: 5 beats, out_ready low 4 cycles after first result
      begin
         int  sent = 0, stall_left = 0, base;
         bit  first = 0, stalling;
         base = popped;
         for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (!first && out_valid) begin
               first = 1;
               stall_left = 4;
            end
            stalling = (stall_left > 0);
            if (stalling) stall_left--;
            out_ready = !stalling;
            in_valid  = (sent < 5);
            in_data   = bp_data(sent);
            in_inv    = 1'b0;
            @(negedge clk);
            if (stalling) begin
               check("bp_hold_valid", out_valid, 1);
               check("bp_hold_data", out_data, exp_word(bp_data(0), 1'b0));
               check("bp_hold_inv", out_inv, 0);
               check("bp_in_ready_low", in_ready, 0);
            end
            if (in_valid && in_ready) sent++;
         end
         @(posedge clk); #1;
         in_valid = 1'b0;
         check("bp_sent", sent, 5);
         check("bp_received", popped - base, 5);
         check("bp_drained", sb_q.size(), 0);
      end

      // ---- random mixed-mode traffic
      run_random(60, 600);

      // ---- two beats in flight, then reset
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA5A5A5A5; in_inv = 1'b0;
      @(posedge clk); #1;
      in_data = 32'h5A5A5A5A; in_inv = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("flight_out_valid", out_valid, 1);
      check("flight_in_ready", in_ready, 0);
      @(negedge clk); #2;
      rst = 1'b1;
      #1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_out_data", out_data, 0);
      check("midrst_in_ready", in_ready, 0);
      sb_q.delete();
      @(posedge clk);
      @(negedge clk); #1;
      rst = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("no_stale_beat", out_valid, 0);
      end
      run_random(40, 400);
      sb_en = 1'b0;

      // ---- LANES = 16: all 256 bytes in both modes
      for (int m = 0; m < 2; m++) begin
         for (int k = 0; k < 18; k++) begin
            @(posedge clk); #1;
            if (k >= 2) begin
               logic [127:0] e;
               for (int i = 0; i < 16; i++)
                  e[8*i +: 8] = m[0] ? model_inv[(k-2)*16 + i] : model_fwd[(k-2)*16 + i];
               check("l16_valid", ov16, 1);
               check("l16_data", od16, e);
               check("l16_inv", oinv16, m[0]);
            end
            v16   = (k < 16);
            inv16 = m[0];
            for (int i = 0; i < 16; i++) d16[8*i +: 8] = 8'(k*16 + i);
         end
         @(posedge clk); #1;
         v16 = 1'b0;
      end

      // ---- LANES = 1, INV_EN = 0: in_inv ignored, out_inv forced low
      begin
         logic [7:0] src [22];
         for (int k = 0; k < 22; k++) src[k] = (k == 0) ? 8'h00 : 8'($urandom);
         for (int k = 0; k < 22; k++) begin
            @(posedge clk); #1;
            if (k >= 2) begin
               check("fwdonly_valid", ovf, 1);
               check("fwdonly_data", odf, model_fwd[src[k-2]]);
               check("fwdonly_inv", oinvf, 0);
            end
            vf   = (k < 20);
            invf = 1'b1;
            df   = src[k];
         end
         @(posedge clk); #1;
         vf = 1'b0;
      end

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
